// File: rtl/game_pkg.sv
// Shared constants, glyphs and converter state type for the reaction-game display path.
package game_pkg;

    // Game phase encodings carried on `select`
    localparam logic [1:0] SEL_MODE  = 2'd0;
    localparam logic [1:0] SEL_RAND  = 2'd1;
    localparam logic [1:0] SEL_COUNT = 2'd2;
    localparam logic [1:0] SEL_SCORE = 2'd3;

    // Difficulty encodings carried on `mode`
    localparam logic [1:0] MODE_EASY = 2'd0;
    localparam logic [1:0] MODE_REG  = 2'd1;
    localparam logic [1:0] MODE_HARD = 2'd2;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] G_0     = 7'b1000000;
    localparam logic [6:0] G_1     = 7'b1111001;
    localparam logic [6:0] G_2     = 7'b0100100;
    localparam logic [6:0] G_3     = 7'b0110000;
    localparam logic [6:0] G_4     = 7'b0011001;
    localparam logic [6:0] G_5     = 7'b0010010;
    localparam logic [6:0] G_6     = 7'b0000010;
    localparam logic [6:0] G_7     = 7'b1111000;
    localparam logic [6:0] G_8     = 7'b0000000;
    localparam logic [6:0] G_9     = 7'b0010000;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_R     = 7'b0101111;
    localparam logic [6:0] G_H     = 7'b0001001;

    // Sequential double-dabble converter states
    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } conv_state_t;

    // Decimal digit to segment pattern; non-decimal nibbles show a dash
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return G_0;
            4'd1:    return G_1;
            4'd2:    return G_2;
            4'd3:    return G_3;
            4'd4:    return G_4;
            4'd5:    return G_5;
            4'd6:    return G_6;
            4'd7:    return G_7;
            4'd8:    return G_8;
            4'd9:    return G_9;
            default: return G_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 14-bit binary to 4-digit BCD converter, one result every 16 cycles.
module bin2bcd_seq
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic        valid
);

    conv_state_t state, state_nx;
    logic [13:0] snap;
    logic [13:0] sh;
    logic [15:0] acc;
    logic [15:0] acc_adj;
    logic [3:0]  iter;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nx;
    end

    // Next-state logic: LOAD -> 14x SHIFT -> DONE -> LOAD
    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:  state_nx = S_SHIFT;
            S_SHIFT: if (iter == 4'd13) state_nx = S_DONE;
            S_DONE:  state_nx = S_LOAD;
            default: state_nx = S_LOAD;
        endcase
    end

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Converter datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            snap  <= '0;
            sh    <= '0;
            acc   <= '0;
            iter  <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_LOAD: begin
                    snap <= bin;
                    sh   <= bin;
                    acc  <= '0;
                    iter <= '0;
                end
                S_SHIFT: begin
                    {acc, sh} <= {acc_adj, sh} << 1;
                    iter      <= iter + 4'd1;
                end
                S_DONE: begin
                    bcd   <= acc;
                    ovf   <= (snap > 14'd9999);
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg_display.sv
// Basys3 4-digit multiplexed seven-segment driver for the reaction game.
module seg_display
    import game_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  select,
    input  logic [1:0]  mode,
    input  logic [13:0] number,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        bcd_valid
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    idx;
    logic [15:0]   bcd;
    logic          ovf;
    logic [3:0]    digit;
    logic          lead_zero;
    logic [6:0]    glyph;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .bin   (number),
        .bcd   (bcd),
        .ovf   (ovf),
        .valid (bcd_valid)
    );

    // Refresh counter; digit index advances on each wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Glyph selection for the current digit index
    always_comb begin
        digit     = bcd[{idx, 2'b00} +: 4];
        lead_zero = 1'b0;
        case (idx)
            2'd1:    lead_zero = (bcd[15:4]  == '0);
            2'd2:    lead_zero = (bcd[15:8]  == '0);
            2'd3:    lead_zero = (bcd[15:12] == '0);
            default: lead_zero = 1'b0;
        endcase
        glyph = digit_glyph(digit);
        if (select == SEL_MODE) begin
            glyph = G_BLANK;
            if (idx == 2'd0) begin
                case (mode)
                    MODE_EASY: glyph = G_E;
                    MODE_REG:  glyph = G_R;
                    MODE_HARD: glyph = G_H;
                    default:   glyph = G_DASH;
                endcase
            end
        end else if (ovf) begin
            glyph = G_DASH;
        end else if (BLANK_LZ && lead_zero) begin
            glyph = G_BLANK;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= '1;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= glyph;
            an  <= ~(4'b0001 << idx);
            dp  <= ~((select == SEL_SCORE) && (idx == 2'd0));
        end
    end

endmodule

// File: tb/tb_seg_display.sv
// Randomized self-checking bench for seg_display against a decimal-arithmetic display model.
module tb_seg_display;

    localparam int unsigned R = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  select;
    logic [1:0]  mode;
    logic [13:0] number;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic        dp_a, dp_b, v_a, v_b;

    int k = 0;
    int n_tests = 0;
    int n_fail = 0;
    int m_sel, m_mode, m_num;

    logic [6:0] dig_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg_display #(.REFRESH_DIV(R), .BLANK_LZ(1'b1)) u_lz (
        .clk(clk), .rst(rst), .select(select), .mode(mode), .number(number),
        .seg(seg_a), .an(an_a), .dp(dp_a), .bcd_valid(v_a)
    );

    seg_display #(.REFRESH_DIV(R), .BLANK_LZ(1'b0)) u_nolz (
        .clk(clk), .rst(rst), .select(select), .mode(mode), .number(number),
        .seg(seg_b), .an(an_b), .dp(dp_b), .bcd_valid(v_b)
    );

    always #5 clk = ~clk;

    // Cycles since reset release
    always @(posedge clk) k <= rst ? 0 : k + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic [6:0] model_seg(input int sel, input int md, input int num,
                                              input int idx, input bit blz);
        int p;
        if (sel == 0) begin
            if (idx != 0) return 7'b1111111;
            case (md)
                0:       return 7'b0000110;
                1:       return 7'b0101111;
                2:       return 7'b0001001;
                default: return 7'b0111111;
            endcase
        end
        if (num > 9999) return 7'b0111111;
        p = 1;
        for (int j = 0; j < idx; j++) p = p * 10;
        if (blz && idx > 0 && num < p) return 7'b1111111;
        return dig_tab[(num / p) % 10];
    endfunction

    task automatic check_display(input string tag, input int cycles);
        int idx;
        logic [3:0] exp_an;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            idx    = ((k - 1) / int'(R)) % 4;
            exp_an = 4'hF ^ (4'h1 << idx);
            check({tag, " an"},    32'(an_a),  32'(exp_an));
            check({tag, " an_nz"}, 32'(an_b),  32'(exp_an));
            check({tag, " seg"},   32'(seg_a), 32'(model_seg(m_sel, m_mode, m_num, idx, 1'b1)));
            check({tag, " seg_nz"},32'(seg_b), 32'(model_seg(m_sel, m_mode, m_num, idx, 1'b0)));
            check({tag, " dp"},    32'(dp_a),  32'((m_sel == 3 && idx == 0) ? 1'b0 : 1'b1));
            check({tag, " valid"}, 32'(v_a),   32'((k > 0) && (k % 16 == 0)));
        end
    endtask

    task automatic apply(input string tag, input int sel, input int md, input int num);
        @(negedge clk);
        select = 2'(sel);
        mode   = 2'(md);
        number = 14'(num);
        m_sel  = sel;
        m_mode = md;
        m_num  = num;
        repeat (40) @(posedge clk);
        check_display(tag, 16);
    endtask

    initial begin
        int r, w;
        rst    = 1'b1;
        select = 2'd2;
        mode   = 2'd0;
        number = 14'd1234;
        m_sel  = 2;
        m_mode = 0;
        m_num  = 0;

        repeat (3) begin
            @(negedge clk);
            check("rst seg",   32'(seg_a), 32'h7F);
            check("rst an",    32'(an_a),  32'hF);
            check("rst dp",    32'(dp_a),  32'h1);
            check("rst valid", 32'(v_a),   32'h0);
        end
        rst = 1'b0;

        check_display("first", 16);
        m_num = 1234;
        check_display("1234", 16);

        apply("seven", 2, 0, 7);
        apply("zero", 2, 0, 0);
        apply("9999", 2, 0, 9999);
        apply("10000", 1, 0, 10000);
        apply("16383", 3, 0, 16383);
        apply("score42", 3, 0, 42);
        apply("mode E", 0, 0, 1234);
        apply("mode r", 0, 1, 1234);
        apply("mode H", 0, 2, 1234);
        apply("mode 3", 0, 3, 1234);

        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       w = $urandom_range(0, 9);
                1:       w = $urandom_range(0, 9999);
                2:       w = $urandom_range(9990, 10010);
                default: w = $urandom_range(0, 16383);
            endcase
            apply("rand", $urandom_range(0, 3), $urandom_range(0, 3), w);
        end

        // Reset five cycles into a conversion
        apply("pre-mid", 3, 0, 42);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!v_a && w < 40);
        check("mid valid seen", 32'(v_a), 32'h1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        m_num = 0;
        check_display("midrst zero", 16);
        m_num = 42;
        check_display("midrst 42", 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
